// File: rtl/pu_inter_bin_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pu_inter_bin_sched
//  Description : Orders the inter-prediction syntax bins of one prediction
//                unit: inter_pred_idc (via external binarizer), ref_idx_l0,
//                mvp_l0_flag, ref_idx_l1, mvp_l1_flag. Delivers them one bin
//                per ready/valid handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_inter_bin_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       pu_valid,
    output logic       pu_ready,
    input  logic       pu_b_slice,
    input  logic [1:0] pu_inter_pred_idc,
    input  logic [3:0] pu_nPbW,
    input  logic [3:0] pu_nPbH,
    input  logic [3:0] pu_ref_idx_l0,
    input  logic [3:0] pu_ref_idx_l1,
    input  logic [3:0] pu_cmax_l0,
    input  logic [3:0] pu_cmax_l1,
    input  logic [1:0] pu_mvp_flags,
    output logic       ipi_start,
    output logic [1:0] ipi_inter_pred_idc,
    output logic [3:0] ipi_nPbW,
    output logic [3:0] ipi_nPbH,
    input  logic       ipi_bin_valid,
    input  logic       ipi_bin_value,
    input  logic       ipi_done,
    output logic       bin_valid,
    output logic       bin_value,
    output logic [2:0] bin_ctx_sel,
    output logic       bin_last,
    input  logic       bin_ready
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        IPI_START = 3'd1,
        IPI_WAIT  = 3'd2,
        REF_L0    = 3'd3,
        MVP_L0    = 3'd4,
        REF_L1    = 3'd5,
        MVP_L1    = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_after_idc;
    state_t     w_after_mvp0;

    logic [1:0] r_idc;
    logic [3:0] r_npbw;
    logic [3:0] r_npbh;
    logic [3:0] r_ref0;
    logic [3:0] r_ref1;
    logic [3:0] r_cmax0;
    logic [3:0] r_cmax1;
    logic [1:0] r_mvp;
    logic [3:0] r_cnt;
    logic       r_done_seen;

    logic [1:0] r_fifo;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic       w_accept;
    logic       w_push;
    logic       w_pop;
    logic       w_cnt_clr;
    logic       w_cnt_inc_en;
    logic [3:0] w_cnt_inc;
    logic [3:0] w_ref_sel;
    logic [3:0] w_cmax_sel;
    logic       w_ref_final;
    logic [1:0] w_idc_clamped;

    assign w_accept      = (r_state == IDLE) && pu_valid;
    assign w_push        = ipi_bin_valid && ((r_state == IPI_START) || (r_state == IPI_WAIT));
    assign w_cnt_inc     = r_cnt + 4'd1;
    assign w_ref_sel     = (r_state == REF_L1) ? r_ref1  : r_ref0;
    assign w_cmax_sel    = (r_state == REF_L1) ? r_cmax1 : r_cmax0;
    // Truncated unary ends on the '0' bin, or on the last '1' when ref == cmax.
    assign w_ref_final   = (r_cnt == w_ref_sel) || (w_cnt_inc == w_cmax_sel);
    assign w_idc_clamped = (pu_inter_pred_idc == 2'd3) ? 2'd2 : pu_inter_pred_idc;

    assign ipi_start          = (r_state == IPI_START);
    assign ipi_inter_pred_idc = r_idc;
    assign ipi_nPbW           = r_npbw;
    assign ipi_nPbH           = r_npbh;

    // Element following idc / mvp_l0, skipping ref states with a zero cMax.
    always_comb begin
        if (r_idc != 2'd1)
            w_after_idc = (r_cmax0 != 4'd0) ? REF_L0 : MVP_L0;
        else
            w_after_idc = (r_cmax1 != 4'd0) ? REF_L1 : MVP_L1;
        if (r_idc == 2'd0)
            w_after_mvp0 = IDLE;
        else
            w_after_mvp0 = (r_cmax1 != 4'd0) ? REF_L1 : MVP_L1;
    end

    // Next-state and bin output decode.
    always_comb begin
        w_next       = r_state;
        pu_ready     = 1'b0;
        bin_valid    = 1'b0;
        bin_value    = 1'b0;
        bin_ctx_sel  = 3'd0;
        bin_last     = 1'b0;
        w_pop        = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc_en = 1'b0;
        case (r_state)
            IDLE: begin
                pu_ready = 1'b1;
                if (pu_valid) begin
                    if (pu_b_slice)
                        w_next = IPI_START;
                    else
                        w_next = (pu_cmax_l0 != 4'd0) ? REF_L0 : MVP_L0;
                end
            end
            IPI_START: w_next = IPI_WAIT;
            IPI_WAIT: begin
                bin_valid = (r_count != 2'd0);
                bin_value = r_fifo[r_rd_ptr];
                w_pop     = bin_valid && bin_ready;
                if (r_done_seen && (r_count == 2'd0) && !ipi_bin_valid)
                    w_next = w_after_idc;
            end
            REF_L0, REF_L1: begin
                bin_valid   = 1'b1;
                bin_value   = (r_cnt < w_ref_sel);
                bin_ctx_sel = (r_state == REF_L1) ? 3'd3 : 3'd1;
                if (bin_ready) begin
                    if (w_ref_final) begin
                        w_cnt_clr = 1'b1;
                        w_next    = (r_state == REF_L1) ? MVP_L1 : MVP_L0;
                    end else begin
                        w_cnt_inc_en = 1'b1;
                    end
                end
            end
            MVP_L0: begin
                bin_valid   = 1'b1;
                bin_value   = r_mvp[0];
                bin_ctx_sel = 3'd2;
                bin_last    = (r_idc == 2'd0);
                if (bin_ready)
                    w_next = w_after_mvp0;
            end
            MVP_L1: begin
                bin_valid   = 1'b1;
                bin_value   = r_mvp[1];
                bin_ctx_sel = 3'd4;
                bin_last    = 1'b1;
                if (bin_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register, PU field latch and truncated-unary counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idc       <= 2'd0;
            r_npbw      <= 4'd0;
            r_npbh      <= 4'd0;
            r_ref0      <= 4'd0;
            r_ref1      <= 4'd0;
            r_cmax0     <= 4'd0;
            r_cmax1     <= 4'd0;
            r_mvp       <= 2'd0;
            r_cnt       <= 4'd0;
            r_done_seen <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idc       <= pu_b_slice ? w_idc_clamped : 2'd0;
                r_npbw      <= pu_nPbW;
                r_npbh      <= pu_nPbH;
                r_ref0      <= (pu_ref_idx_l0 > pu_cmax_l0) ? pu_cmax_l0 : pu_ref_idx_l0;
                r_ref1      <= (pu_ref_idx_l1 > pu_cmax_l1) ? pu_cmax_l1 : pu_ref_idx_l1;
                r_cmax0     <= pu_cmax_l0;
                r_cmax1     <= pu_cmax_l1;
                r_mvp       <= pu_mvp_flags;
                r_done_seen <= 1'b0;
            end else if (ipi_done && ((r_state == IPI_START) || (r_state == IPI_WAIT))) begin
                r_done_seen <= 1'b1;
            end
            if (w_cnt_clr)
                r_cnt <= 4'd0;
            else if (w_cnt_inc_en)
                r_cnt <= w_cnt_inc;
        end
    end

    // Two-entry FIFO decoupling the non-stallable binarizer from downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo   <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= ipi_bin_value;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            if (w_push && !w_pop)
                r_count <= r_count + 2'd1;
            else if (!w_push && w_pop)
                r_count <= r_count - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pu_inter_bin_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pu_inter_bin_sched
//  Description : Directed self-checking bench for pu_inter_bin_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pu_inter_bin_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       pu_valid;
    logic       pu_ready;
    logic       pu_b_slice;
    logic [1:0] pu_inter_pred_idc;
    logic [3:0] pu_nPbW;
    logic [3:0] pu_nPbH;
    logic [3:0] pu_ref_idx_l0;
    logic [3:0] pu_ref_idx_l1;
    logic [3:0] pu_cmax_l0;
    logic [3:0] pu_cmax_l1;
    logic [1:0] pu_mvp_flags;
    logic       ipi_start;
    logic [1:0] ipi_inter_pred_idc;
    logic [3:0] ipi_nPbW;
    logic [3:0] ipi_nPbH;
    logic       ipi_bin_valid;
    logic       ipi_bin_value;
    logic       ipi_done;
    logic       bin_valid;
    logic       bin_value;
    logic [2:0] bin_ctx_sel;
    logic       bin_last;
    logic       bin_ready;

    int n_tests = 0;
    int n_fail  = 0;

    pu_inter_bin_sched dut (
        .clk                (clk),
        .rst                (rst),
        .pu_valid           (pu_valid),
        .pu_ready           (pu_ready),
        .pu_b_slice         (pu_b_slice),
        .pu_inter_pred_idc  (pu_inter_pred_idc),
        .pu_nPbW            (pu_nPbW),
        .pu_nPbH            (pu_nPbH),
        .pu_ref_idx_l0      (pu_ref_idx_l0),
        .pu_ref_idx_l1      (pu_ref_idx_l1),
        .pu_cmax_l0         (pu_cmax_l0),
        .pu_cmax_l1         (pu_cmax_l1),
        .pu_mvp_flags       (pu_mvp_flags),
        .ipi_start          (ipi_start),
        .ipi_inter_pred_idc (ipi_inter_pred_idc),
        .ipi_nPbW           (ipi_nPbW),
        .ipi_nPbH           (ipi_nPbH),
        .ipi_bin_valid      (ipi_bin_valid),
        .ipi_bin_value      (ipi_bin_value),
        .ipi_done           (ipi_done),
        .bin_valid          (bin_valid),
        .bin_value          (bin_value),
        .bin_ctx_sel        (bin_ctx_sel),
        .bin_last           (bin_last),
        .bin_ready          (bin_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a PU at a negedge, lets it be accepted, returns at the next negedge.
    task automatic accept_pu(input string tag, input logic b, input logic [1:0] idc,
                             input logic [3:0] w, input logic [3:0] h,
                             input logic [3:0] r0, input logic [3:0] r1,
                             input logic [3:0] c0, input logic [3:0] c1,
                             input logic [1:0] mvp);
        pu_b_slice        = b;
        pu_inter_pred_idc = idc;
        pu_nPbW           = w;
        pu_nPbH           = h;
        pu_ref_idx_l0     = r0;
        pu_ref_idx_l1     = r1;
        pu_cmax_l0        = c0;
        pu_cmax_l1        = c1;
        pu_mvp_flags      = mvp;
        pu_valid          = 1'b1;
        chk({tag, "_pu_ready"}, {7'd0, pu_ready}, 8'd1);
        @(negedge clk);
        pu_valid = 1'b0;
    endtask

    // One binarizer bin for one cycle.
    task automatic ipi_emit(input logic v, input logic d);
        ipi_bin_valid = 1'b1;
        ipi_bin_value = v;
        ipi_done      = d;
        @(negedge clk);
        ipi_bin_valid = 1'b0;
        ipi_bin_value = 1'b0;
        ipi_done      = 1'b0;
    endtask

    // Waits (bounded) for a bin, checks it, and lets the handshake happen.
    task automatic expect_bin(input string tag, input logic v, input logic [2:0] ctx,
                              input logic last);
        int i = 0;
        while (!bin_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_valid"}, {7'd0, bin_valid}, 8'd1);
        chk({tag, "_fields"}, {3'd0, bin_value, bin_ctx_sel, bin_last}, {3'd0, v, ctx, last});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pu_valid = 1'b0; pu_b_slice = 1'b0; pu_inter_pred_idc = 2'd0;
        pu_nPbW = 4'd0; pu_nPbH = 4'd0; pu_ref_idx_l0 = 4'd0; pu_ref_idx_l1 = 4'd0;
        pu_cmax_l0 = 4'd0; pu_cmax_l1 = 4'd0; pu_mvp_flags = 2'd0;
        ipi_bin_valid = 1'b0; ipi_bin_value = 1'b0; ipi_done = 1'b0;
        bin_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_pu_ready",  {7'd0, pu_ready},  8'd1);
        chk("rst_ipi_start", {7'd0, ipi_start}, 8'd0);
        chk("rst_bin_outs",  {3'd0, bin_valid, bin_value, bin_last, bin_ctx_sel[1:0]}, 8'd0);
        chk("rst_bin_ctx",   {5'd0, bin_ctx_sel}, 8'd0);
        chk("rst_ipi_outs",  {ipi_inter_pred_idc, ipi_nPbW[2:0], ipi_nPbH[2:0]}, 8'd0);
        rst = 1'b0;
        @(negedge clk);

        // B 8x8 bi-pred, cmax1 = 0 skips ref_l1
        accept_pu("t1", 1'b1, 2'd2, 4'd8, 4'd8, 4'd1, 4'd0, 4'd2, 4'd0, 2'b01);
        chk("t1_ipi_start", {7'd0, ipi_start}, 8'd1);
        chk("t1_ipi_idc",   {6'd0, ipi_inter_pred_idc}, 8'd2);
        chk("t1_ipi_size",  {ipi_nPbW, ipi_nPbH}, 8'h88);
        ipi_emit(1'b1, 1'b1);
        chk("t1_start_pulse", {7'd0, ipi_start}, 8'd0);
        expect_bin("t1_b0", 1'b1, 3'd0, 1'b0);
        expect_bin("t1_b1", 1'b1, 3'd1, 1'b0);
        expect_bin("t1_b2", 1'b0, 3'd1, 1'b0);
        expect_bin("t1_b3", 1'b1, 3'd2, 1'b0);
        expect_bin("t1_b4", 1'b0, 3'd4, 1'b1);
        chk("t1_idle", {6'd0, pu_ready, bin_valid}, 8'd2);

        // P slice, ref0 == cmax0: no terminating zero, no binarizer start
        accept_pu("t2", 1'b0, 2'd2, 4'd8, 4'd8, 4'd2, 4'd0, 4'd2, 4'd0, 2'b00);
        chk("t2_no_ipi_start", {7'd0, ipi_start}, 8'd0);
        expect_bin("t2_b0", 1'b1, 3'd1, 1'b0);
        expect_bin("t2_b1", 1'b1, 3'd1, 1'b0);
        expect_bin("t2_b2", 1'b0, 3'd2, 1'b1);
        chk("t2_idle", {6'd0, pu_ready, bin_valid}, 8'd2);

        // B 8x4 L1-only: L0 elements skipped
        accept_pu("t3", 1'b1, 2'd1, 4'd8, 4'd4, 4'd5, 4'd0, 4'd5, 4'd3, 2'b10);
        chk("t3_ipi_idc",  {6'd0, ipi_inter_pred_idc}, 8'd1);
        chk("t3_ipi_size", {ipi_nPbW, ipi_nPbH}, 8'h84);
        ipi_emit(1'b1, 1'b1);
        expect_bin("t3_b0", 1'b1, 3'd0, 1'b0);
        expect_bin("t3_b1", 1'b0, 3'd3, 1'b0);
        expect_bin("t3_b2", 1'b1, 3'd4, 1'b1);

        // B 8x8 L0-only with downstream stalled while the binarizer emits
        accept_pu("t4", 1'b1, 2'd0, 4'd8, 4'd8, 4'd1, 4'd0, 4'd1, 4'd0, 2'b01);
        bin_ready = 1'b0;
        ipi_emit(1'b0, 1'b0);
        ipi_emit(1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk("t4_stall", {5'd0, bin_valid, bin_value, bin_last}, 8'd4);
            @(negedge clk);
        end
        bin_ready = 1'b1;
        expect_bin("t4_b0", 1'b0, 3'd0, 1'b0);
        expect_bin("t4_b1", 1'b0, 3'd0, 1'b0);
        expect_bin("t4_b2", 1'b1, 3'd1, 1'b0);
        expect_bin("t4_b3", 1'b1, 3'd2, 1'b1);

        // idc 3 clamps to 2; ref indices above cmax clamp to cmax
        accept_pu("t5", 1'b1, 2'd3, 4'd8, 4'd8, 4'd7, 4'd9, 4'd2, 4'd1, 2'b10);
        chk("t5_ipi_idc", {6'd0, ipi_inter_pred_idc}, 8'd2);
        ipi_emit(1'b1, 1'b1);
        expect_bin("t5_b0", 1'b1, 3'd0, 1'b0);
        expect_bin("t5_b1", 1'b1, 3'd1, 1'b0);
        expect_bin("t5_b2", 1'b1, 3'd1, 1'b0);
        expect_bin("t5_b3", 1'b0, 3'd2, 1'b0);
        expect_bin("t5_b4", 1'b1, 3'd3, 1'b0);
        expect_bin("t5_b5", 1'b1, 3'd4, 1'b1);

        // Reset while emitting ref_l0, then a fresh PU
        accept_pu("t6", 1'b0, 2'd0, 4'd8, 4'd8, 4'd3, 4'd0, 4'd5, 4'd0, 2'b00);
        chk("t6_in_ref", {4'd0, bin_valid, bin_ctx_sel}, 8'h09);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_after_rst", {6'd0, pu_ready, bin_valid}, 8'd2);
        chk("t6_rst_ctx",   {5'd0, bin_ctx_sel}, 8'd0);
        rst = 1'b0;
        accept_pu("t6n", 1'b0, 2'd0, 4'd8, 4'd8, 4'd0, 4'd0, 4'd1, 4'd0, 2'b01);
        expect_bin("t6_b0", 1'b0, 3'd1, 1'b0);
        expect_bin("t6_b1", 1'b1, 3'd2, 1'b1);

        // pu_valid held high: one PU per IDLE visit
        pu_b_slice = 1'b0; pu_inter_pred_idc = 2'd0; pu_ref_idx_l0 = 4'd0;
        pu_cmax_l0 = 4'd0; pu_mvp_flags = 2'b01;
        pu_valid = 1'b1;
        chk("t7_ready0", {7'd0, pu_ready}, 8'd1);
        @(negedge clk);
        chk("t7_busy0", {7'd0, pu_ready}, 8'd0);
        expect_bin("t7_b0", 1'b1, 3'd2, 1'b1);
        chk("t7_idle_visit", {6'd0, pu_ready, bin_valid}, 8'd2);
        @(negedge clk);
        chk("t7_busy1", {6'd0, pu_ready, bin_valid}, 8'd1);
        pu_valid = 1'b0;
        expect_bin("t7_b1", 1'b1, 3'd2, 1'b1);
        @(negedge clk);
        chk("t7_no_extra", {6'd0, pu_ready, bin_valid}, 8'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
